// File: rtl/dtree_vote_accum.sv
// -----------------------------------------------------------------------------
// dtree_vote_accum
//   Majority vote over a window of decision-tree predictions. Each accepted
//   prediction increments its class bin. When the window is full, the bins are
//   scanned one per cycle for the largest count. Ties go to the lowest class
//   index. The voted class is then presented on a valid/ready output until the
//   consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort: clear the window and drop any pending result
//   in_valid   in_class carries a prediction
//   in_class   predicted class code
//   in_ready   block is accumulating and will take a prediction this cycle
//   out_valid  voted result is available
//   out_ready  consumer takes the result
//   out_class  majority class of the last completed window
//   out_count  number of votes held by out_class
//   out_err    at least one out-of-range class was seen in that window
// -----------------------------------------------------------------------------
module dtree_vote_accum #(
   parameter int NUM_CLASSES = 10,
   parameter int CLASS_W     = 4,
   parameter int WINDOW      = 16,
   parameter int CNT_W       = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [CLASS_W-1:0] in_class,
   output logic               in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CLASS_W-1:0] out_class,
   output logic [CNT_W-1:0]   out_count,
   output logic               out_err
);

   typedef enum logic [1:0] {ACCUM, SCAN, HOLD} state_e;

   localparam logic [CLASS_W:0]   NUM_CLS_L = (CLASS_W+1)'(NUM_CLASSES);
   localparam logic [CNT_W-1:0]   WINDOW_L  = CNT_W'(WINDOW);
   localparam logic [CLASS_W-1:0] LAST_IDX  = CLASS_W'(NUM_CLASSES - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   bin_q [NUM_CLASSES];
   logic [CNT_W-1:0]   bin_d [NUM_CLASSES];
   logic [CNT_W-1:0]   wcnt_q, wcnt_d;
   logic               err_q, err_d;
   logic [CLASS_W-1:0] idx_q, idx_d;
   logic [CLASS_W-1:0] best_cls_q, best_cls_d;
   logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [CLASS_W-1:0] out_class_q, out_class_d;
   logic [CNT_W-1:0]   out_count_q, out_count_d;
   logic               out_err_q, out_err_d;

   logic               in_range;
   logic [CNT_W-1:0]   scan_bin;
   logic               scan_take;

   // Ready comes from the state register alone, so there is no path from
   // in_valid back to in_ready.
   assign in_ready  = (state_q == ACCUM);
   assign out_valid = out_valid_q;
   assign out_class = out_class_q;
   assign out_count = out_count_q;
   assign out_err   = out_err_q;

   assign in_range  = ({1'b0, in_class} < NUM_CLS_L);
   assign scan_take = (scan_bin > best_cnt_q);   // strict: ties keep lower index

   // Bin read mux for the scan; written as a loop so that an index past the
   // last class reads 0 instead of going out of range.
   always_comb begin
      scan_bin = '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
         if (idx_q == CLASS_W'(c)) scan_bin = bin_q[c];
      end
   end

   // NOTE: every signal gets its hold value first, so no path can leave one
   // unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      wcnt_d      = wcnt_q;
      err_d       = err_q;
      idx_d       = idx_q;
      best_cls_d  = best_cls_q;
      best_cnt_d  = best_cnt_q;
      out_valid_d = out_valid_q;
      out_class_d = out_class_q;
      out_count_d = out_count_q;
      out_err_d   = out_err_q;

      if (flush) begin
         // Abort: the window and any pending result are lost. The last
         // result value stays on out_class/out_count.
         state_d     = ACCUM;
         wcnt_d      = '0;
         err_d       = 1'b0;
         out_valid_d = 1'b0;
         for (int c = 0; c < NUM_CLASSES; c++) bin_d[c] = '0;
      end else begin
         unique case (state_q)
            ACCUM: begin
               if (in_valid) begin
                  wcnt_d = wcnt_q + 1'b1;
                  if (in_range) begin
                     for (int c = 0; c < NUM_CLASSES; c++) begin
                        if (in_class == CLASS_W'(c)) bin_d[c] = bin_q[c] + 1'b1;
                     end
                  end else begin
                     err_d = 1'b1;
                  end
                  if (wcnt_q + 1'b1 == WINDOW_L) begin
                     state_d    = SCAN;
                     idx_d      = '0;
                     best_cls_d = '0;
                     best_cnt_d = '0;
                  end
               end
            end
            SCAN: begin
               if (scan_take) begin
                  best_cls_d = idx_q;
                  best_cnt_d = scan_bin;
               end
               idx_d = idx_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  // The last bin is folded in directly here, so the result
                  // is loaded on the same edge that inspects it.
                  out_class_d = scan_take ? idx_q : best_cls_q;
                  out_count_d = scan_take ? scan_bin : best_cnt_q;
                  out_err_d   = err_q;
                  out_valid_d = 1'b1;
                  state_d     = HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_d     = ACCUM;
                  wcnt_d      = '0;
                  err_d       = 1'b0;
                  out_valid_d = 1'b0;
                  for (int c = 0; c < NUM_CLASSES; c++) bin_d[c] = '0;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ACCUM;
      else        state_q <= state_d;
   end

   // NOTE: the bin array is a small register file that must start at zero
   // for the first window, so it is reset like every other register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CLASSES; c++) bin_q[c] <= '0;
         wcnt_q      <= '0;
         err_q       <= 1'b0;
         idx_q       <= '0;
         best_cls_q  <= '0;
         best_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_class_q <= '0;
         out_count_q <= '0;
         out_err_q   <= 1'b0;
      end else begin
         bin_q       <= bin_d;
         wcnt_q      <= wcnt_d;
         err_q       <= err_d;
         idx_q       <= idx_d;
         best_cls_q  <= best_cls_d;
         best_cnt_q  <= best_cnt_d;
         out_valid_q <= out_valid_d;
         out_class_q <= out_class_d;
         out_count_q <= out_count_d;
         out_err_q   <= out_err_d;
      end
   end

endmodule
